execute_stage_p: RTL

- Parametrised execute stage between decode and writeback.
- Adds to a single-cycle ALU:
  - valid/ready handshakes on both sides
  - an explicit writeback enable
  - a registered branch-taken flag with target PC
  - a multi-cycle multiplier with stall
  - a sticky halt state that replaces a simulation stop.
- Consumes one decoded instruction per handshake and produces one result record per instruction, in order.

---
 rtl/execute_stage_p.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/execute_stage_p.sv
// Execute stage between decode and writeback: single-cycle ALU, valid/ready on both
// sides, registered branch resolution, a multi-cycle multiplier and a sticky halt.
module execute_stage_p #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int IMM_W   = 16,
    parameter int MUL_LAT = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [DATA_W-1:0]  in_rs,
    input  logic [DATA_W-1:0]  in_rt,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [RADDR_W-1:0] in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_we,
    output logic [DATA_W-1:0]  out_pc,
    output logic               out_branch,
    output logic               halted
);
    // state    | meaning
    // RUN      | accepting one instruction per cycle whenever the output slot frees
    // MUL_BUSY | multiply in flight; down-counter runs to 1, then the product loads
    // HALTED   | HLT accepted; nothing more is accepted until reset
    typedef enum logic [1:0] {RUN, MUL_BUSY, HALTED} state_t;

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(MUL_LAT);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_LI  = 4'd2,  OP_SLL = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7;
    localparam logic [3:0] OP_BR  = 4'd8,  OP_BNE = 4'd9,  OP_MOV = 4'd10, OP_ADI = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12, OP_HLT = 4'd13;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0]    mul_a, mul_b, mul_pc, product;
    logic [RADDR_W-1:0]   mul_rd;
    logic                 out_free, accept, load_alu, load_mul, mul_start;
    logic [DATA_W-1:0]    simm, zimm, alu_data, alu_pc;
    logic                 alu_we, alu_branch;
    logic [SH_W-1:0]      shamt;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == RUN) && out_free;
    assign accept   = in_valid && in_ready;
    assign halted   = (state == HALTED);

    assign simm    = DATA_W'($signed(in_imm));
    assign zimm    = DATA_W'(in_imm);
    assign shamt   = in_imm[SH_W-1:0];
    assign product = mul_a * mul_b;

    always_comb begin
        alu_data   = '0;
        alu_we     = 1'b1;
        alu_branch = 1'b0;
        alu_pc     = in_pc;
        case (in_op)
            OP_ADD: alu_data = in_rs + in_rt;
            OP_SUB: alu_data = in_rs - in_rt;
            OP_LI:  alu_data = zimm;
            OP_SLL: alu_data = in_rs << shamt;
            OP_SRL: alu_data = in_rs >> shamt;
            OP_AND: alu_data = in_rs & in_rt;
            OP_OR:  alu_data = in_rs | in_rt;
            OP_XOR: alu_data = in_rs ^ in_rt;
            OP_MOV: alu_data = in_rs;
            OP_ADI: alu_data = in_rs + simm;
            OP_BR: begin
                alu_we     = 1'b0;
                alu_branch = 1'b1;
                alu_pc     = in_pc + simm;
            end
            OP_BNE: begin
                alu_we = 1'b0;
                if (in_rs != in_rt) begin
                    alu_branch = 1'b1;
                    alu_pc     = in_pc + simm;
                end
            end
            // HLT and NOPs write nothing; MUL never loads through this path
            default: alu_we = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state)
            RUN: begin
                if (accept) begin
                    if (in_op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nxt = MUL_BUSY;
                        cnt_nxt   = CNT_W'(MUL_LAT - 1);
                    end else begin
                        load_alu = 1'b1;
                        if (in_op == OP_HLT) state_nxt = HALTED;
                    end
                end
            end
            MUL_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    if (out_free) begin
                        load_mul  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = HALTED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= RUN;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_pc     <= '0;
            mul_rd     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_rd     <= '0;
            out_we     <= 1'b0;
            out_pc     <= '0;
            out_branch <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (mul_start) begin
                mul_a  <= in_rs;
                mul_b  <= in_rt;
                mul_pc <= in_pc;
                mul_rd <= in_rd;
            end
            if (load_alu) begin
                out_valid  <= 1'b1;
                out_data   <= alu_data;
                out_rd     <= in_rd;
                out_we     <= alu_we;
                out_pc     <= alu_pc;
                out_branch <= alu_branch;
            end else if (load_mul) begin
                out_valid  <= 1'b1;
                out_data   <= product;
                out_rd     <= mul_rd;
                out_we     <= 1'b1;
                out_pc     <= mul_pc;
                out_branch <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
